divide_operand_prep_16: RTL and testbench
=========================================

Name: divide_operand_prep_16

Overview:
Upstream operand-conditioning stage for newton_raphson_divide_16. It accepts signed 16-bit dividend N and divisor D over a valid/ready handshake and passes them through a 2-stage pipeline. Outputs are unsigned magnitudes, a normalized divisor (MSB set), its shift count, the quotient sign, and exception flags. Downstream, the divider's reciprocal iteration consumes a normalized divisor, and the final quotient is re-signed, truncating toward zero.

Parameters:
WIDTH, 16, operand width in bits; two's-complement signed inputs.
SHW, 4, shift-count width, equal to $clog2(WIDTH).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  input operands valid.
in_ready  output  1  stage can accept this cycle.
in_n  input  WIDTH  signed dividend N.
in_d  input  WIDTH  signed divisor D.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts this cycle.
out_n_mag  output  WIDTH  |N| as unsigned; 0x8000 for N=-32768.
out_d_norm  output  WIDTH  |D| << out_d_shift; MSB=1 unless D=0.
out_d_shift  output  SHW  leading-zero count of |D|, 0..15.
out_q_neg  output  1  quotient is negative.
out_div_by_zero  output  1  D == 0.
out_overflow  output  1  N == 0x8000 and D == 0xFFFF; true quotient +32768 does not fit.

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous and active-high. On reset, both stage valid bits clear and all output data registers go to 0. After reset, in_ready=1 and out_valid=0.
- Reset mid-operation: any in-flight operands are discarded. No output is produced for them.
- Handshake:
  - Input transfer occurs on in_valid && in_ready.
  - Output transfer occurs on out_valid && out_ready.
  - Output data holds stable while out_valid && !out_ready.
  - in_valid must not depend on in_ready.
- Stage 1 (S1) registers, captured on input transfer:
  - n_mag = N[15] ? -N : N, kept as an unsigned WIDTH-bit value.
  - d_mag, computed the same way from D.
  - q_neg = (N[15] ^ D[15]) && (N != 0).
  - dz = (D == 0).
  - ovf = (N == 0x8000) && (D == 0xFFFF).
- Stage 2 (S2) registers:
  - shift = lzc(d_mag); d_norm = d_mag << shift.
  - If dz: shift=0, d_norm=0.
  - All other S1 fields pass through.
- Pipeline control (full-throughput, bubble-collapsing):
  - s2_advance = !s2_valid || out_ready.
  - s1_advance = !s1_valid || s2_advance.
  - in_ready = s1_advance.
  - S2 loads when s1_valid && s2_advance; s2_valid follows s1_valid whenever s2_advance.
  - S1 loads on input transfer; s1_valid follows in_valid whenever s1_advance.
- Latency and throughput: latency 2 cycles from input transfer to out_valid. Throughput is 1 op/cycle with out_ready held high.
- Backpressure: with out_ready low, at most 2 ops are held. in_ready drops only when both stages are full. There is no combinational path from in_valid to out_valid.
- Simultaneous input and output transfer in the same cycle with the pipe full: legal. No op is lost or duplicated.
- Exception flags: divide-by-zero and overflow are flagged only. Operands still flow through so the downstream stage decides the result.
- Ordering: strictly in order.

Decomposition:
- Shared package div_pkg: WIDTH=16, SHW=4, INT_MIN constant 16'h8000, and a packed struct div_operands_t {n_mag, d_norm, d_shift, q_neg, dz, ovf}, reused by the divider and the post-normalization stage.
- One sub-module: lzc_16, a combinational leading-zero counter. Output is 0..15; input 0 returns 0 and the caller masks it with dz.

Test Plan:
- Single op, N=8, D=2, out_ready=1 -> 2 cycles later: n_mag=8, d_norm=0x8000, d_shift=14, q_neg=0, flags 0.
- Signed operand cases:
  - N=-8 (0xFFF8), D=2 -> n_mag=8, d_norm=0x8000, d_shift=14, q_neg=1.
  - N=4971, D=-93 -> n_mag=4971, d_norm=0xBA00, d_shift=9, q_neg=1.
- Back-to-back ops, one per cycle: (239,17) then (20,5).
  - First result: n_mag=239, d_norm=0x8800, d_shift=11.
  - Second result: n_mag=20, d_norm=0xA000, d_shift=13.
  - Results appear on consecutive cycles.
- Boundary operands:
  - D=0, N=5 -> div_by_zero=1, d_norm=0, d_shift=0.
  - N=0x8000, D=0xFFFF -> overflow=1, n_mag=0x8000, d_norm=0x8000, d_shift=15, q_neg=0.
  - N=0, D=-3 -> q_neg=0.
- Backpressure: out_ready=0 while 3 ops are offered.
  - in_ready drops after 2 accepts; output holds the first op stably.
  - Release out_ready -> all 3 ops emerge in order, none dropped or duplicated.
- Reset mid-operation: assert rst for 1 cycle with 2 ops in flight.
  - Next cycle: out_valid=0, in_ready=1, outputs 0.
  - A new op then completes with 2-cycle latency.

Source files
------------

// File: rtl/div_pkg.sv
// Shared operand-format definitions for the 16-bit Newton-Raphson divider path.
package div_pkg;
   localparam int WIDTH = 16;
   localparam int SHW   = 4;
   localparam logic [WIDTH-1:0] INT_MIN = 16'h8000;

   typedef struct packed {
      logic [WIDTH-1:0] n_mag;
      logic [WIDTH-1:0] d_norm;
      logic [SHW-1:0]   d_shift;
      logic             q_neg;
      logic             dz;
      logic             ovf;
   } div_operands_t;
endpackage

// File: rtl/lzc_16.sv
// Combinational leading-zero counter; an all-zero input reports 0 and must be
// masked by the caller.
module lzc_16
   import div_pkg::*;
(
   input  logic [WIDTH-1:0] i_val,
   output logic [SHW-1:0]   o_cnt
);
   // Scanning upward lets the highest set bit win the last assignment.
   always_comb begin
      o_cnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (i_val[i]) o_cnt = SHW'(WIDTH - 1 - i);
      end
   end
endmodule

// File: rtl/divide_operand_prep_16.sv
// Two-stage operand conditioning: magnitudes, sign and flags in S1, divisor
// normalisation in S2, with a bubble-collapsing valid/ready pipeline.
module divide_operand_prep_16
   import div_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_n,
   input  logic [WIDTH-1:0] in_d,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_n_mag,
   output logic [WIDTH-1:0] out_d_norm,
   output logic [SHW-1:0]   out_d_shift,
   output logic             out_q_neg,
   output logic             out_div_by_zero,
   output logic             out_overflow
);
   logic             r_s1_valid;
   logic [WIDTH-1:0] r_s1_n_mag;
   logic [WIDTH-1:0] r_s1_d_mag;
   logic             r_s1_q_neg;
   logic             r_s1_dz;
   logic             r_s1_ovf;

   logic             r_s2_valid;
   div_operands_t    r_s2;

   logic             w_s1_advance;
   logic             w_s2_advance;
   logic [WIDTH-1:0] w_n_mag;
   logic [WIDTH-1:0] w_d_mag;
   logic [SHW-1:0]   w_lzc;
   logic [SHW-1:0]   w_shift;
   logic [WIDTH-1:0] w_d_norm;

   assign w_s2_advance = !r_s2_valid || out_ready;
   assign w_s1_advance = !r_s1_valid || w_s2_advance;
   assign in_ready     = w_s1_advance;

   // INT_MIN negates to itself, which is exactly its unsigned magnitude.
   assign w_n_mag = in_n[WIDTH-1] ? WIDTH'(0) - in_n : in_n;
   assign w_d_mag = in_d[WIDTH-1] ? WIDTH'(0) - in_d : in_d;

   lzc_16 u_lzc (
      .i_val (r_s1_d_mag),
      .o_cnt (w_lzc)
   );

   assign w_shift  = r_s1_dz ? '0 : w_lzc;
   assign w_d_norm = r_s1_dz ? '0 : r_s1_d_mag << w_shift;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_n_mag <= '0;
         r_s1_d_mag <= '0;
         r_s1_q_neg <= 1'b0;
         r_s1_dz    <= 1'b0;
         r_s1_ovf   <= 1'b0;
         r_s2_valid <= 1'b0;
         r_s2       <= '0;
      end else begin
         if (w_s1_advance) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
               r_s1_n_mag <= w_n_mag;
               r_s1_d_mag <= w_d_mag;
               r_s1_q_neg <= (in_n[WIDTH-1] ^ in_d[WIDTH-1]) && (in_n != '0);
               r_s1_dz    <= (in_d == '0);
               r_s1_ovf   <= (in_n == INT_MIN) && (in_d == '1);
            end
         end
         if (w_s2_advance) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_s2.n_mag   <= r_s1_n_mag;
               r_s2.d_norm  <= w_d_norm;
               r_s2.d_shift <= w_shift;
               r_s2.q_neg   <= r_s1_q_neg;
               r_s2.dz      <= r_s1_dz;
               r_s2.ovf     <= r_s1_ovf;
            end
         end
      end
   end

   assign out_valid       = r_s2_valid;
   assign out_n_mag       = r_s2.n_mag;
   assign out_d_norm      = r_s2.d_norm;
   assign out_d_shift     = r_s2.d_shift;
   assign out_q_neg       = r_s2.q_neg;
   assign out_div_by_zero = r_s2.dz;
   assign out_overflow    = r_s2.ovf;
endmodule

// File: tb/tb_divide_operand_prep_16.sv
// Directed bench for divide_operand_prep_16: a vector table for single ops plus
// hand-written back-to-back, backpressure and mid-flight reset sequences.
module tb_divide_operand_prep_16;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_n;
   logic [15:0] in_d;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_n_mag;
   logic [15:0] out_d_norm;
   logic [3:0]  out_d_shift;
   logic        out_q_neg;
   logic        out_div_by_zero;
   logic        out_overflow;

   int compared   = 0;
   int mismatched = 0;

   divide_operand_prep_16 dut (
      .clk             (clk),
      .rst             (rst),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_n            (in_n),
      .in_d            (in_d),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_n_mag       (out_n_mag),
      .out_d_norm      (out_d_norm),
      .out_d_shift     (out_d_shift),
      .out_q_neg       (out_q_neg),
      .out_div_by_zero (out_div_by_zero),
      .out_overflow    (out_overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [15:0] n;
      logic [15:0] d;
      logic [15:0] n_mag;
      logic [15:0] d_norm;
      logic [3:0]  shift;
      logic        q_neg;
      logic        dz;
      logic        ovf;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [15:0] n_mag, input logic [15:0] d_norm,
                          input logic [3:0] shift, input logic q_neg, input logic dz, input logic ovf);
      chk({tag, ".out_valid"},  32'(out_valid),       32'(1'b1));
      chk({tag, ".n_mag"},      32'(out_n_mag),       32'(n_mag));
      chk({tag, ".d_norm"},     32'(out_d_norm),      32'(d_norm));
      chk({tag, ".d_shift"},    32'(out_d_shift),     32'(shift));
      chk({tag, ".q_neg"},      32'(out_q_neg),       32'(q_neg));
      chk({tag, ".div_by_zero"},32'(out_div_by_zero), 32'(dz));
      chk({tag, ".overflow"},   32'(out_overflow),    32'(ovf));
      $display("%s: n_mag=%h d_norm=%h shift=%0d q_neg=%b dz=%b ovf=%b", tag,
               out_n_mag, out_d_norm, out_d_shift, out_q_neg, out_div_by_zero, out_overflow);
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0] = '{"n8_d2",        16'd8,    16'd2,    16'd8,    16'h8000, 4'd14, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{"nm8_d2",       16'hFFF8, 16'd2,    16'd8,    16'h8000, 4'd14, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{"n4971_dm93",   16'd4971, 16'hFFA3, 16'd4971, 16'hBA00, 4'd9,  1'b1, 1'b0, 1'b0};
      vecs[3] = '{"n5_d0",        16'd5,    16'd0,    16'd5,    16'h0000, 4'd0,  1'b0, 1'b1, 1'b0};
      vecs[4] = '{"intmin_dm1",   16'h8000, 16'hFFFF, 16'h8000, 16'h8000, 4'd15, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{"n0_dm3",       16'd0,    16'hFFFD, 16'd0,    16'hC000, 4'd14, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{"intmin_d1",    16'h8000, 16'd1,    16'h8000, 16'h8000, 4'd15, 1'b1, 1'b0, 1'b0};
      vecs[7] = '{"nm1_dintmin",  16'hFFFF, 16'h8000, 16'd1,    16'h8000, 4'd0,  1'b0, 1'b0, 1'b0};
      vecs[8] = '{"n100_dmax",    16'd100,  16'h7FFF, 16'd100,  16'hFFFE, 4'd1,  1'b0, 1'b0, 1'b0};
      vecs[9] = '{"nm5_d0",       16'hFFFB, 16'd0,    16'd5,    16'h0000, 4'd0,  1'b1, 1'b1, 1'b0};

      rst = 1'b1; in_valid = 1'b0; in_n = '0; in_d = '0; out_ready = 1'b1;
      step(); step();
      rst = 1'b0;
      #1;
      chk("reset.out_valid", 32'(out_valid), 32'd0);
      chk("reset.in_ready",  32'(in_ready),  32'd1);
      chk("reset.n_mag",     32'(out_n_mag), 32'd0);
      chk("reset.d_norm",    32'(out_d_norm),32'd0);
      step();

      // Table: one op at a time, 2-cycle latency each.
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_n = vecs[i].n; in_d = vecs[i].d;
         chk({vecs[i].name, ".in_ready"}, 32'(in_ready), 32'd1);
         step();
         in_valid = 1'b0;
         chk({vecs[i].name, ".early_valid"}, 32'(out_valid), 32'd0);
         step();
         chk_out(vecs[i].name, vecs[i].n_mag, vecs[i].d_norm, vecs[i].shift,
                 vecs[i].q_neg, vecs[i].dz, vecs[i].ovf);
         step();
         chk({vecs[i].name, ".drained"}, 32'(out_valid), 32'd0);
      end

      // Back-to-back ops produce results on consecutive cycles.
      in_valid = 1'b1; in_n = 16'd239; in_d = 16'd17;
      step();
      in_n = 16'd20; in_d = 16'd5;
      step();
      in_valid = 1'b0;
      chk_out("b2b_first", 16'd239, 16'h8800, 4'd11, 1'b0, 1'b0, 1'b0);
      step();
      chk_out("b2b_second", 16'd20, 16'hA000, 4'd13, 1'b0, 1'b0, 1'b0);
      step();
      chk("b2b.drained", 32'(out_valid), 32'd0);

      // Backpressure: three ops offered with out_ready low.
      out_ready = 1'b0;
      in_valid = 1'b1; in_n = 16'd11; in_d = 16'd1;
      step();
      in_n = 16'd22; in_d = 16'd2;
      chk("bp.in_ready_one_held", 32'(in_ready), 32'd1);
      step();
      in_n = 16'd33; in_d = 16'd3;
      chk("bp.in_ready_full", 32'(in_ready), 32'd0);
      chk_out("bp_hold0", 16'd11, 16'h8000, 4'd15, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) begin
         step();
         chk("bp.in_ready_stall", 32'(in_ready), 32'd0);
         chk_out("bp_hold", 16'd11, 16'h8000, 4'd15, 1'b0, 1'b0, 1'b0);
      end
      out_ready = 1'b1;
      #1;
      chk("bp.in_ready_release", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      chk_out("bp_second", 16'd22, 16'h8000, 4'd14, 1'b0, 1'b0, 1'b0);
      step();
      chk_out("bp_third", 16'd33, 16'hC000, 4'd14, 1'b0, 1'b0, 1'b0);
      step();
      chk("bp.drained", 32'(out_valid), 32'd0);

      // Reset with two ops in flight discards both.
      in_valid = 1'b1; in_n = 16'hFF00; in_d = 16'd7;
      step();
      in_n = 16'd44; in_d = 16'd9;
      step();
      in_valid = 1'b0;
      chk("rst_mid.pre_valid", 32'(out_valid), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_mid.out_valid", 32'(out_valid),   32'd0);
      chk("rst_mid.in_ready",  32'(in_ready),    32'd1);
      chk("rst_mid.n_mag",     32'(out_n_mag),   32'd0);
      chk("rst_mid.d_norm",    32'(out_d_norm),  32'd0);
      chk("rst_mid.d_shift",   32'(out_d_shift), 32'd0);
      chk("rst_mid.q_neg",     32'(out_q_neg),   32'd0);
      step();
      chk("rst_mid.no_ghost", 32'(out_valid), 32'd0);
      in_valid = 1'b1; in_n = 16'd8; in_d = 16'd2;
      step();
      in_valid = 1'b0;
      chk("rst_mid.new_early", 32'(out_valid), 32'd0);
      step();
      chk_out("rst_mid_new", 16'd8, 16'h8000, 4'd14, 1'b0, 1'b0, 1'b0);
      step();
      chk("rst_mid.drained", 32'(out_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
